// File: rtl/fetch_stage_if.sv
// Package and interface shared by the instruction-fetch stage.
//
// fetch_pkg
//   ifid_t     : IF|ID pipeline latch contents (imemload, pc_plus), 64 bits.
//
// fetch_stage_if : every non-clock signal of the fetch stage.
//   iREN        fetch -> cache   instruction read enable
//   iaddr       fetch -> cache   fetch address (the PC)
//   ihit        cache -> fetch   iload is valid this cycle
//   iload       cache -> fetch   instruction word
//   stall       hazard -> fetch  hold PC and IF|ID
//   redirect    EX|MEM -> fetch  taken branch/jump resolved
//   redirect_pc EX|MEM -> fetch  redirect target (low two bits ignored)
//   halt        MEM|WB -> fetch  halt instruction retired
//   ifid        fetch -> decode  registered IF|ID latch
//   ifid_valid  fetch -> decode  latch holds a real instruction
// The master modport is the fetch stage itself; slave is its environment.

package fetch_pkg;
    typedef struct packed {
        logic [31:0] imemload;
        logic [31:0] pc_plus;
    } ifid_t;
endpackage

interface fetch_stage_if;
    import fetch_pkg::*;

    logic        iREN;
    logic [31:0] iaddr;
    logic        ihit;
    logic [31:0] iload;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        halt;
    ifid_t       ifid;
    logic        ifid_valid;

    modport master (
        output iREN, iaddr, ifid, ifid_valid,
        input  ihit, iload, stall, redirect, redirect_pc, halt
    );

    modport slave (
        input  iREN, iaddr, ifid, ifid_valid,
        output ihit, iload, stall, redirect, redirect_pc, halt
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage of the five-stage pipeline.
// Owns the program counter, drives the instruction-cache request and
// produces the registered IF|ID latch consumed by decode.
//
// Parameters
//   PC_INIT : PC loaded on reset (word aligned).
// Ports
//   CLK     : clock, all state updates on the rising edge
//   RST     : synchronous reset, active-high
//   bus     : fetch_stage_if.master (cache request/response, hazard,
//             redirect, halt and the IF|ID latch outputs)
//
// Per-edge priority: reset, halt (sticky), redirect, stall, hit, miss.

module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
    input  logic          CLK,
    input  logic          RST,
    fetch_stage_if.master bus
);

    logic [31:0] pc;
    ifid_t       ifidQ;
    logic        ifidValidQ;
    logic        halted;
    logic [31:0] pcPlus4;

    // 32-bit modulo add: 0xFFFF_FFFC wraps to 0 with no carry-out kept.
    assign pcPlus4 = pc + 32'd4;

    assign bus.iaddr      = pc;
    assign bus.iREN       = !halted;
    assign bus.ifid       = ifidQ;
    assign bus.ifid_valid = ifidValidQ;

    // NOTE: every state register below uses non-blocking assignment so all
    // of them sample the pre-edge values of one another; blocking here would
    // make pc + 4 see an already-updated pc and change behaviour with order.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pc         <= PC_INIT;
            ifidQ      <= '0;
            ifidValidQ <= 1'b0;
            halted     <= 1'b0;
        end else if (halted || bus.halt) begin
            // Once halted, fetch freezes until reset; a nop fills IF|ID.
            halted     <= 1'b1;
            ifidQ      <= '0;
            ifidValidQ <= 1'b0;
        end else if (bus.redirect) begin
            // Redirect wins over stall: the instruction being fetched is on
            // the wrong path, so it is dropped and a bubble goes to decode.
            pc         <= bus.redirect_pc & 32'hFFFF_FFFC;
            ifidQ      <= '0;
            ifidValidQ <= 1'b0;
        end else if (bus.stall) begin
            pc         <= pc;
            ifidQ      <= ifidQ;
            ifidValidQ <= ifidValidQ;
        end else if (bus.ihit) begin
            ifidQ.imemload <= bus.iload;
            ifidQ.pc_plus  <= pcPlus4;
            ifidValidQ     <= 1'b1;
            pc             <= pcPlus4;
        end else begin
            // Miss: retry the same address; iload is never sampled here so
            // an undefined word on the bus cannot leak into IF|ID.
            ifidQ      <= '0;
            ifidValidQ <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage.
// Instance dut0 uses the default PC_INIT; dut1 uses 0xFFFF_FFFC to cover
// the PC wrap. Inputs change 1 ns after the rising edge, outputs are
// checked at the same point (settled, away from the edge).

module tb_fetch_stage;
    import fetch_pkg::*;

    logic CLK = 1'b0;
    logic RST;
    int   testsRun  = 0;
    int   testsFail = 0;

    always #5 CLK = ~CLK;

    fetch_stage_if bus0 ();
    fetch_stage_if bus1 ();

    fetch_stage #(.PC_INIT(32'h0000_0000)) dut0 (
        .CLK (CLK),
        .RST (RST),
        .bus (bus0.master)
    );

    fetch_stage #(.PC_INIT(32'hFFFF_FFFC)) dut1 (
        .CLK (CLK),
        .RST (RST),
        .bus (bus1.master)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        testsRun++;
        assert (obs === exp)
        else begin
            testsFail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        // Defaults for both instances.
        RST              = 1'b1;
        bus0.ihit        = 1'b1;
        bus0.iload       = 32'hDEAD_BEEF;
        bus0.stall       = 1'b0;
        bus0.redirect    = 1'b0;
        bus0.redirect_pc = 32'h0;
        bus0.halt        = 1'b0;
        bus1.ihit        = 1'b0;
        bus1.iload       = 32'h0;
        bus1.stall       = 1'b0;
        bus1.redirect    = 1'b0;
        bus1.redirect_pc = 32'h0;
        bus1.halt        = 1'b0;

        // Reset held two cycles with a hit on the bus.
        for (int i = 0; i < 2; i++) begin
            step();
            check("rst_ifid",  bus0.ifid,       64'h0);
            check("rst_valid", bus0.ifid_valid, 64'h0);
            check("rst_iaddr", bus0.iaddr,      64'h0);
            check("rst_iren",  bus0.iREN,       64'h1);
        end
        check("rst_iaddr_wrapinst", bus1.iaddr, 64'hFFFF_FFFC);

        // Streaming hits.
        RST        = 1'b0;
        bus0.iload = 32'h2001_0005;
        step();
        check("s1_ifid",  bus0.ifid,       {32'h2001_0005, 32'h4});
        check("s1_valid", bus0.ifid_valid, 64'h1);
        check("s1_iaddr", bus0.iaddr,      64'h4);
        bus0.iload = 32'h2002_0007;
        step();
        check("s2_ifid",  bus0.ifid,       {32'h2002_0007, 32'h8});
        check("s2_iaddr", bus0.iaddr,      64'h8);

        // Two misses with an undefined bus word.
        bus0.ihit  = 1'b0;
        bus0.iload = 'x;
        for (int i = 0; i < 2; i++) begin
            step();
            check("miss_iaddr", bus0.iaddr,      64'h8);
            check("miss_valid", bus0.ifid_valid, 64'h0);
            check("miss_ifid",  bus0.ifid,       64'h0);
        end

        // Stall with a hit present: everything holds.
        bus0.ihit  = 1'b1;
        bus0.iload = 32'hCAFE_0000;
        bus0.stall = 1'b1;
        step();
        check("stall_ifid",  bus0.ifid,  64'h0);
        check("stall_iaddr", bus0.iaddr, 64'h8);

        // Hit at 8, then stall must hold a valid latch.
        bus0.stall = 1'b0;
        bus0.iload = 32'hAAAA_0001;
        step();
        check("hit8_ifid",  bus0.ifid,  {32'hAAAA_0001, 32'hC});
        check("hit8_iaddr", bus0.iaddr, 64'hC);
        bus0.stall = 1'b1;
        bus0.iload = 32'hBBBB_0002;
        step();
        check("stallv_ifid",  bus0.ifid,       {32'hAAAA_0001, 32'hC});
        check("stallv_valid", bus0.ifid_valid, 64'h1);
        check("stallv_iaddr", bus0.iaddr,      64'hC);

        // Redirect beats stall and hit; low address bits dropped.
        bus0.redirect    = 1'b1;
        bus0.redirect_pc = 32'h0000_0043;
        step();
        check("redir_iaddr", bus0.iaddr,      64'h40);
        check("redir_ifid",  bus0.ifid,       64'h0);
        check("redir_valid", bus0.ifid_valid, 64'h0);
        bus0.redirect = 1'b0;
        bus0.stall    = 1'b0;
        bus0.iload    = 32'h1111_2222;
        step();
        check("redir_pcplus", bus0.ifid.pc_plus, 64'h44);
        check("redir_load",   bus0.ifid.imemload, 64'h1111_2222);
        check("redir_iaddr2", bus0.iaddr,        64'h44);

        // Halt pulse, then a redirect that must be ignored.
        bus0.halt  = 1'b1;
        bus0.iload = 32'h7777_7777;
        step();
        check("halt_iren",  bus0.iREN,       64'h0);
        check("halt_iaddr", bus0.iaddr,      64'h44);
        check("halt_valid", bus0.ifid_valid, 64'h0);
        check("halt_ifid",  bus0.ifid,       64'h0);
        bus0.halt        = 1'b0;
        bus0.redirect    = 1'b1;
        bus0.redirect_pc = 32'h0000_0100;
        for (int i = 0; i < 3; i++) begin
            step();
            check("halted_iren",  bus0.iREN,       64'h0);
            check("halted_iaddr", bus0.iaddr,      64'h44);
            check("halted_valid", bus0.ifid_valid, 64'h0);
        end

        // Reset while a redirect is pending restarts at PC_INIT.
        RST = 1'b1;
        step();
        check("rst2_iaddr", bus0.iaddr,      64'h0);
        check("rst2_iren",  bus0.iREN,       64'h1);
        check("rst2_valid", bus0.ifid_valid, 64'h0);
        RST           = 1'b0;
        bus0.redirect = 1'b0;
        bus0.iload    = 32'h3333_4444;
        step();
        check("resume_ifid",  bus0.ifid,  {32'h3333_4444, 32'h4});
        check("resume_iaddr", bus0.iaddr, 64'h4);
        check("resume_iren",  bus0.iREN,  64'h1);

        // PC wrap on the second instance.
        check("wrap_pre_iaddr", bus1.iaddr, 64'hFFFF_FFFC);
        bus1.ihit  = 1'b1;
        bus1.iload = 32'h5555_6666;
        step();
        check("wrap_pcplus", bus1.ifid.pc_plus,  64'h0);
        check("wrap_load",   bus1.ifid.imemload, 64'h5555_6666);
        check("wrap_iaddr",  bus1.iaddr,         64'h0);
        check("wrap_valid",  bus1.ifid_valid,    64'h1);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFail);
        $finish;
    end

endmodule
